// File: rtl/axi_node_pkg.sv
// Shared definitions for the AXI node blocks.
//   RESP_DECERR     : BRESP encoding for a decode error.
//   wr_err_state_e  : states of the write decode-error responder.
package axi_node_pkg;

    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURED,
        DRAIN,
        DONE,
        RESP
    } wr_err_state_e;

endpackage : axi_node_pkg

// File: rtl/axi_write_decerr_responder.sv
// Terminates a write burst whose AW address decoded to no init port: captures
// the AW ID/USER/LEN, sinks the W beats while the decoder hands over the W
// channel, then returns one DECERR B beat.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   sample_awdata_info_i     decoder accepted an erroneous AW (capture strobe)
//   awid_i/awuser_i/awlen_i  AW fields of the failed burst
//   handle_error_i           decoder grants this block the W channel
//   wvalid_i/wlast_i         slave-port W handshake inputs
//   wready_o                 W ready (only while draining)
//   wdata_error_completed_o  one-cycle pulse after the WLAST handshake
//   error_req_i              decoder requests the error B beat
//   error_gnt_o              error B beat handshaken
//   bvalid_o/bready_i        error B handshake
//   bid_o/bresp_o/buser_o    B fields (captured ID/USER, constant DECERR)
//   len_mismatch_o           sticky: WLAST arrived on a beat other than AWLEN+1
module axi_write_decerr_responder
    import axi_node_pkg::*;
#(
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sample_awdata_info_i,
    input  logic [AXI_ID_WIDTH-1:0]   awid_i,
    input  logic [AXI_USER_WIDTH-1:0] awuser_i,
    input  logic [7:0]                awlen_i,
    input  logic                      handle_error_i,
    input  logic                      wvalid_i,
    input  logic                      wlast_i,
    output logic                      wready_o,
    output logic                      wdata_error_completed_o,
    input  logic                      error_req_i,
    output logic                      error_gnt_o,
    output logic                      bvalid_o,
    input  logic                      bready_i,
    output logic [AXI_ID_WIDTH-1:0]   bid_o,
    output logic [1:0]                bresp_o,
    output logic [AXI_USER_WIDTH-1:0] buser_o,
    output logic                      len_mismatch_o
);

    wr_err_state_e state_q, state_d;

    logic [AXI_ID_WIDTH-1:0]   awid_q;
    logic [AXI_USER_WIDTH-1:0] awuser_q;
    logic [7:0]                awlen_q;
    logic [7:0]                beat_cnt_q;
    logic                      len_mismatch_q;
    logic                      w_hs;

    assign w_hs = wvalid_i & wready_o;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (sample_awdata_info_i) state_d = CAPTURED;
            CAPTURED: if (handle_error_i)       state_d = DRAIN;
            DRAIN:    if (w_hs && wlast_i)      state_d = DONE;
            DONE:                               state_d = RESP;
            RESP:     if (error_gnt_o)          state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    // Outputs: all decoded from the registered state, so the completed pulse
    // lands one cycle after the WLAST handshake.
    always_comb begin
        wready_o                = (state_q == DRAIN) & handle_error_i;
        bvalid_o                = (state_q == RESP) & error_req_i;
        error_gnt_o             = bvalid_o & bready_i;
        wdata_error_completed_o = (state_q == DONE);
    end

    // Capture registers, beat counter and length check.
    // beat_cnt counts beats before the current one, so on the WLAST beat it
    // should equal AWLEN; it saturates so an overlong burst still drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            awid_q         <= '0;
            awuser_q       <= '0;
            awlen_q        <= '0;
            beat_cnt_q     <= '0;
            len_mismatch_q <= 1'b0;
        end else begin
            if (state_q == IDLE && sample_awdata_info_i) begin
                awid_q     <= awid_i;
                awuser_q   <= awuser_i;
                awlen_q    <= awlen_i;
                beat_cnt_q <= '0;
            end else if (w_hs) begin
                if (beat_cnt_q != 8'hFF) begin
                    beat_cnt_q <= beat_cnt_q + 8'd1;
                end
                if (wlast_i && (beat_cnt_q != awlen_q)) begin
                    len_mismatch_q <= 1'b1;
                end
            end
        end
    end

    assign bid_o          = awid_q;
    assign buser_o        = awuser_q;
    assign bresp_o        = RESP_DECERR;
    assign len_mismatch_o = len_mismatch_q;

endmodule : axi_write_decerr_responder

// File: tb/tb_axi_write_decerr_responder.sv
// Self-checking bench for axi_write_decerr_responder. Each burst is described
// at transaction level (ID, USER, AWLEN, number of beats up to WLAST, W/B
// stall behaviour) and expected outputs follow from the protocol rules.
module tb_axi_write_decerr_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample;
    logic [3:0] awid;
    logic [5:0] awuser;
    logic [7:0] awlen;
    logic       handle;
    logic       wvalid;
    logic       wlast;
    logic       wready;
    logic       completed;
    logic       error_req;
    logic       error_gnt;
    logic       bvalid;
    logic       bready;
    logic [3:0] bid;
    logic [1:0] bresp;
    logic [5:0] buser;
    logic       len_mismatch;

    int checks   = 0;
    int failures = 0;
    bit exp_mm   = 1'b0;

    always #5 clk = ~clk;

    axi_write_decerr_responder #(
        .AXI_ID_WIDTH  (4),
        .AXI_USER_WIDTH(6)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .sample_awdata_info_i   (sample),
        .awid_i                 (awid),
        .awuser_i               (awuser),
        .awlen_i                (awlen),
        .handle_error_i         (handle),
        .wvalid_i               (wvalid),
        .wlast_i                (wlast),
        .wready_o               (wready),
        .wdata_error_completed_o(completed),
        .error_req_i            (error_req),
        .error_gnt_o            (error_gnt),
        .bvalid_o               (bvalid),
        .bready_i               (bready),
        .bid_o                  (bid),
        .bresp_o                (bresp),
        .buser_o                (buser),
        .len_mismatch_o         (len_mismatch)
    );

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        sample = 0; handle = 0; wvalid = 0; wlast = 0; error_req = 0; bready = 0;
    endtask

    // One complete error burst. Called and returns at posedge+1 with the DUT idle.
    task automatic run_burst(input logic [3:0] id, input logic [5:0] user,
                             input logic [7:0] len, input int nbeats,
                             input int wmode, input int stall_b,
                             input bit eager, input bit b2b);
        int  beats = 0;
        int  cyc   = 0;
        bit  done  = 0;
        int  sat;
        // Sample in IDLE
        sample = 1; awid = id; awuser = user; awlen = len;
        handle = 0; wvalid = 0; wlast = 0; error_req = 0; bready = 0;
        @(negedge clk);
        checks++; if (wready !== 1'b0) begin failures++; $display("FAIL idle_wready got=%0b exp=0", wready); end
        step();
        sample = 0; awid = 4'($urandom); awuser = 6'($urandom); awlen = 8'($urandom);
        // Captured: WLAST presented here must not be taken
        handle = 1; wvalid = 1; wlast = (nbeats == 1);
        @(negedge clk);
        checks++; if (wready !== 1'b0) begin failures++; $display("FAIL cap_wready got=%0b exp=0", wready); end
        step();
        // Drain
        while (!done && cyc < 4000) begin
            handle = eager ? 1'b1 : ($urandom_range(0, 99) < 85);
            if (wmode < 0) wvalid = ((cyc % 2) == 0);
            else           wvalid = ($urandom_range(0, 99) < wmode);
            wlast = (beats == nbeats - 1);
            @(negedge clk);
            checks++; if (wready !== handle) begin failures++; $display("FAIL drain_wready got=%0b exp=%0b", wready, handle); end
            checks++; if (completed !== 1'b0) begin failures++; $display("FAIL drain_completed got=%0b exp=0", completed); end
            if (wvalid && handle) begin
                beats++;
                if (wlast) done = 1;
            end
            step();
            cyc++;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL drain_timeout beats=%0d required=%0d", beats, nbeats);
        end
        sat = (nbeats - 1 > 255) ? 255 : nbeats - 1;
        if (sat != int'(len)) exp_mm = 1'b1;
        // Completed pulse; W and early error_req are ignored here
        handle = 1; wvalid = 1; wlast = 1; error_req = 1; bready = 1;
        @(negedge clk);
        checks++; if (completed !== 1'b1) begin failures++; $display("FAIL done_completed got=%0b exp=1", completed); end
        checks++; if (wready !== 1'b0) begin failures++; $display("FAIL done_wready got=%0b exp=0", wready); end
        checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL done_bvalid got=%0b exp=0", bvalid); end
        checks++; if (len_mismatch !== exp_mm) begin failures++; $display("FAIL done_mismatch got=%0b exp=%0b", len_mismatch, exp_mm); end
        step();
        handle = 0; wvalid = 0; wlast = 0;
        // Response
        if (stall_b > 0) begin
            error_req = 0; bready = 1'($urandom);
            @(negedge clk);
            checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL resp_noreq_bvalid got=%0b exp=0", bvalid); end
            checks++; if (completed !== 1'b0) begin failures++; $display("FAIL resp_completed got=%0b exp=0", completed); end
            step();
        end
        error_req = 1; bready = 0;
        for (int i = 0; i < stall_b; i++) begin
            @(negedge clk);
            checks++; if (bvalid !== 1'b1) begin failures++; $display("FAIL stall_bvalid got=%0b exp=1", bvalid); end
            checks++; if (error_gnt !== 1'b0) begin failures++; $display("FAIL stall_gnt got=%0b exp=0", error_gnt); end
            checks++; if (bid !== id) begin failures++; $display("FAIL stall_bid got=%0h exp=%0h", bid, id); end
            checks++; if (buser !== user) begin failures++; $display("FAIL stall_buser got=%0h exp=%0h", buser, user); end
            step();
        end
        bready = 1;
        @(negedge clk);
        checks++; if (bvalid !== 1'b1) begin failures++; $display("FAIL b_bvalid got=%0b exp=1", bvalid); end
        checks++; if (error_gnt !== 1'b1) begin failures++; $display("FAIL b_gnt got=%0b exp=1", error_gnt); end
        checks++; if (bid !== id) begin failures++; $display("FAIL b_bid got=%0h exp=%0h", bid, id); end
        checks++; if (buser !== user) begin failures++; $display("FAIL b_buser got=%0h exp=%0h", buser, user); end
        checks++; if (bresp !== 2'b11) begin failures++; $display("FAIL b_bresp got=%0b exp=11", bresp); end
        checks++; if (len_mismatch !== exp_mm) begin failures++; $display("FAIL b_mismatch got=%0b exp=%0b", len_mismatch, exp_mm); end
        step();
        clear_inputs();
        if (!b2b) begin
            // Back in IDLE: stray controls have no effect
            handle = 1; wvalid = 1; error_req = 1; bready = 1;
            @(negedge clk);
            checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL post_bvalid got=%0b exp=0", bvalid); end
            checks++; if (wready !== 1'b0) begin failures++; $display("FAIL post_wready got=%0b exp=0", wready); end
            step();
            clear_inputs();
        end
    endtask

    task automatic test_reset();
        clear_inputs(); awid = 0; awuser = 0; awlen = 0;
        rst_n = 0;
        step(); step();
        @(negedge clk);
        checks++; if (wready !== 1'b0) begin failures++; $display("FAIL rst_wready got=%0b exp=0", wready); end
        checks++; if (completed !== 1'b0) begin failures++; $display("FAIL rst_completed got=%0b exp=0", completed); end
        checks++; if (error_gnt !== 1'b0) begin failures++; $display("FAIL rst_gnt got=%0b exp=0", error_gnt); end
        checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL rst_bvalid got=%0b exp=0", bvalid); end
        checks++; if (bid !== 4'h0) begin failures++; $display("FAIL rst_bid got=%0h exp=0", bid); end
        checks++; if (buser !== 6'h0) begin failures++; $display("FAIL rst_buser got=%0h exp=0", buser); end
        checks++; if (bresp !== 2'b11) begin failures++; $display("FAIL rst_bresp got=%0b exp=11", bresp); end
        checks++; if (len_mismatch !== 1'b0) begin failures++; $display("FAIL rst_mismatch got=%0b exp=0", len_mismatch); end
        rst_n = 1;
        step();
        exp_mm = 0;
    endtask

    task automatic test_single_beat();
        run_burst(4'h5, 6'h2A, 8'd0, 1, 100, 0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_burst(4'hA, 6'h13, 8'd7, 8, -1, 0, 1'b1, 1'b0);
    endtask

    task automatic test_len_mismatch();
        run_burst(4'h3, 6'h01, 8'd3, 3, 100, 0, 1'b1, 1'b0);
        run_burst(4'h4, 6'h3F, 8'd1, 2, 70, 1, 1'b1, 1'b0);
    endtask

    task automatic test_b_stall();
        run_burst(4'hC, 6'h25, 8'd2, 3, 100, 5, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_drain();
        sample = 1; awid = 4'hE; awuser = 6'h15; awlen = 8'd3;
        step();
        sample = 0; handle = 1; wvalid = 1; wlast = 0;
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (wready !== 1'b1) begin failures++; $display("FAIL mid_wready got=%0b exp=1", wready); end
            step();
        end
        rst_n = 0; error_req = 1; bready = 1;
        step();
        rst_n = 1;
        @(negedge clk);
        checks++; if (wready !== 1'b0) begin failures++; $display("FAIL mid_rst_wready got=%0b exp=0", wready); end
        checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL mid_rst_bvalid got=%0b exp=0", bvalid); end
        checks++; if (bid !== 4'h0) begin failures++; $display("FAIL mid_rst_bid got=%0h exp=0", bid); end
        checks++; if (buser !== 6'h0) begin failures++; $display("FAIL mid_rst_buser got=%0h exp=0", buser); end
        checks++; if (completed !== 1'b0) begin failures++; $display("FAIL mid_rst_completed got=%0b exp=0", completed); end
        checks++; if (len_mismatch !== 1'b0) begin failures++; $display("FAIL mid_rst_mismatch got=%0b exp=0", len_mismatch); end
        exp_mm = 0;
        step();
        clear_inputs();
        run_burst(4'h9, 6'h0C, 8'd3, 4, 80, 2, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        // 300 beats against AWLEN=255: counter pins at 255, so no mismatch.
        run_burst(4'h7, 6'h11, 8'd255, 300, 100, 0, 1'b1, 1'b0);
    endtask

    task automatic test_stray();
        for (int i = 0; i < 8; i++) begin
            handle = 1'($urandom); error_req = 1'($urandom); wvalid = 1'($urandom);
            wlast = 1'($urandom); bready = 1'($urandom);
            @(negedge clk);
            checks++; if (wready !== 1'b0) begin failures++; $display("FAIL stray_wready got=%0b exp=0", wready); end
            checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL stray_bvalid got=%0b exp=0", bvalid); end
            checks++; if (error_gnt !== 1'b0) begin failures++; $display("FAIL stray_gnt got=%0b exp=0", error_gnt); end
            checks++; if (completed !== 1'b0) begin failures++; $display("FAIL stray_completed got=%0b exp=0", completed); end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        run_burst(4'h1, 6'h05, 8'd0, 1, 100, 0, 1'b1, 1'b1);
        run_burst(4'h2, 6'h0A, 8'd1, 2, 100, 0, 1'b1, 1'b1);
        run_burst(4'h6, 6'h30, 8'd0, 1, 100, 0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            logic [7:0] len;
            int         nb;
            len = 8'($urandom_range(0, 15));
            nb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : int'(len) + 1;
            run_burst(4'($urandom), 6'($urandom), len, nb, int'($urandom_range(30, 100)),
                      int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_backpressure();
        test_len_mismatch();
        test_b_stall();
        test_reset_mid_drain();
        test_saturation();
        test_stray();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_axi_write_decerr_responder

// File: doc/axi_write_decerr_responder.md
# axi_write_decerr_responder

Terminates write bursts whose AW address matched no reachable init port in the AXI node. It sits beside the per-target-port AW address decoder and captures the failed burst's ID/USER/LEN when the decoder accepts the bad AW. It sinks the matching W beats while the decoder signals error handling, then issues a single B beat with DECERR through the response path. It is the responder end of the decoder's sample / handle / completed / req / gnt error handshake.

## Interface
- AXI_ID_WIDTH, default 4: width of AWID/BID.
- AXI_USER_WIDTH, default 6: width of AWUSER/BUSER.
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- sample_awdata_info_i  in  1  decoder accepted an erroneous AW this cycle.
- awid_i  in  AXI_ID_WIDTH  AWID of the slave-port AW.
- awuser_i  in  AXI_USER_WIDTH  AWUSER of the slave-port AW.
- awlen_i  in  8  AWLEN of the slave-port AW.
- handle_error_i  in  1  decoder grants this block the slave-port W channel.
- wvalid_i  in  1  slave-port W valid.
- wlast_i  in  1  slave-port W last.
- wready_o  out  1  W ready from this block.
- wdata_error_completed_o  out  1  one-cycle pulse: error burst fully drained.
- error_req_i  in  1  decoder requests the error B response.
- error_gnt_o  out  1  error B beat handshaken.
- bvalid_o  out  1  error B valid to the B response mux.
- bready_i  in  1  B ready from the response mux.
- bid_o  out  AXI_ID_WIDTH  captured AWID.
- bresp_o  out  2  constant 2'b11 (DECERR).
- buser_o  out  AXI_USER_WIDTH  captured AWUSER.
- len_mismatch_o  out  1  sticky flag: the WLAST beat did not equal AWLEN+1.

## Operation
- FSM states and transitions:
  - IDLE → CAPTURED on sample_awdata_info_i. On that edge, latch awid_i, awuser_i and awlen_i, and clear beat_cnt.
  - CAPTURED → DRAIN when handle_error_i=1.
  - DRAIN: wready_o = handle_error_i. On each wvalid_i&wready_o, beat_cnt increments (8-bit). A handshake with wlast_i=1 → DONE.
  - DONE: wdata_error_completed_o=1 for exactly this cycle, then → RESP.
  - RESP: bvalid_o = error_req_i and error_gnt_o = bvalid_o & bready_i. A handshake → IDLE.
- len_mismatch_o is set on the WLAST handshake if beat_cnt+1 ≠ awlen_lat+1 (8-bit compare on beat_cnt vs awlen_lat). It is cleared only by reset.
- W data content is discarded.
- Ignored inputs:
  - sample_awdata_info_i outside IDLE (the protocol forbids it).
  - handle_error_i outside CAPTURED/DRAIN.
  - error_req_i outside RESP, where bvalid_o stays 0.
- wready_o is 0 in every state except DRAIN.
- beat_cnt saturates at 255. The drain continues until WLAST regardless of count.

## Timing
- Reset values: wready_o=0, wdata_error_completed_o=0, error_gnt_o=0, bvalid_o=0, bid_o=0, buser_o=0, len_mismatch_o=0. bresp_o is always 2'b11. FSM resets to IDLE.
- Reset mid-burst returns to IDLE on the next edge and drops all captured state.
- wready_o, bvalid_o and error_gnt_o are combinational from state and inputs. wdata_error_completed_o is registered (state-decoded), one cycle after the WLAST handshake.
- Minimum sequence for AWLEN=0 with all inputs eager:
  - cycle 0: sample.
  - cycle 1: CAPTURED sees handle → DRAIN.
  - cycle 2: W beat.
  - cycle 3: completed pulse.
  - cycle 4: B handshake.
  - cycle 5: IDLE. A new sample is accepted on that cycle.
- A WLAST beat presented in the cycle of the CAPTURED→DRAIN transition is not accepted, because wready_o=0 in CAPTURED.
- bvalid_o, once asserted, follows error_req_i. The decoder holds error_req_i until the grant, so the AXI valid-stability rule holds.

## Structure
- The shared axi_node package holds:
  - the DECERR constant (2'b11);
  - the FSM state enum {IDLE, CAPTURED, DRAIN, DONE, RESP}, encoded in logic [2:0].
- No sub-module. The block is a single FSM plus capture registers and the beat counter.

## Test plan
- Single-beat error: sample with awid=4'h5, awlen=0. Then handle_error_i=1 and one W beat with wlast → completed pulse 1 cycle later. With error_req_i=1 and bready_i=1 → bvalid_o=1, bid_o=5, bresp_o=2'b11, error_gnt_o=1; FSM back in IDLE.
- Burst with W backpressure: awlen=7, wvalid_i toggling every other cycle → exactly 8 beats accepted, completed pulse follows the 8th, len_mismatch_o=0.
- Length mismatch: awlen=3, wlast_i on beat 2 → drain ends at beat 2 and len_mismatch_o=1, sticky through the next clean burst.
- B stall: bready_i=0 for 5 cycles with error_req_i=1 → bvalid_o held at 1 with stable bid_o/buser_o, error_gnt_o=0 until bready_i rises.
- Reset mid-drain: rst_n=0 after 2 of 4 beats → next edge gives IDLE, wready_o=0, bvalid_o=0. A fresh error sequence then completes normally.
- Stray controls: handle_error_i, error_req_i and wvalid_i driven in IDLE → wready_o=0, bvalid_o=0, no completed pulse.
